alu_issue_queue: RTL and testbench



---
 rtl/alu_pkg.sv | 49 ++++
 rtl/alu_issue_fifo.sv | 52 +++++
 rtl/alu_issue_queue.sv | 137 +++++++++++++
 tb/tb_alu_issue_queue.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU control codes, RISC-V funct3 values and the issue-entry layout
// used by the issue queue and its FIFO.
package alu_pkg;

  localparam int TAG_W = 3;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_OR   = 4'b0010;
  localparam logic [3:0] ALU_AND  = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1000;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ctrl;
  } issue_t;

  localparam int ISSUE_W = $bits(issue_t);

  function automatic logic [3:0] f3_to_ctrl(input logic [2:0] f3, input logic sub);
    logic [3:0] code;
    case (f3)
      F3_ADD:  code = sub ? ALU_SUB : ALU_ADD;
      F3_SLL:  code = ALU_SLL;
      F3_SLT:  code = ALU_SLT;
      F3_SLTU: code = ALU_SLTU;
      F3_XOR:  code = ALU_XOR;
      F3_SR:   code = ALU_SRL;
      F3_OR:   code = ALU_OR;
      default: code = ALU_AND;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/alu_issue_fifo.sv
// Synchronous FIFO holding decoded ALU operations; head entry is always
// presented on rdata_o, push is ignored when full and pop when empty.
module alu_issue_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 68,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic [AW:0]      count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & (count_q != '0);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/alu_issue_queue.sv
// ALU issue queue: decodes funct3/funct7 requests, buffers them, and issues
// one tagged operation per cycle with a matching delayed result tag.
module alu_issue_queue
  import alu_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_funct3,
  input  logic             in_funct7b5,
  input  logic             in_is_imm,
  input  logic [31:0]      in_rs1,
  input  logic [31:0]      in_rs2,
  input  logic [31:0]      in_imm,
  input  logic             stall,
  output logic [31:0]      alu_A,
  output logic [31:0]      alu_B,
  output logic [3:0]       alu_ctrl,
  output logic             alu_valid,
  output logic [TAG_W-1:0] alu_tag,
  output logic             res_valid,
  output logic [TAG_W-1:0] res_tag,
  output logic             illegal
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic             dec_legal;
  logic             dec_sub;
  logic             dec_shift;
  issue_t           dec_entry;
  issue_t           head;
  logic [ISSUE_W-1:0] head_raw;
  logic             fifo_full;
  logic [CW-1:0]    fifo_count;
  logic             accept;
  logic             push;
  logic             pop;

  logic [31:0]      alu_a_q;
  logic [31:0]      alu_b_q;
  logic [3:0]       alu_ctrl_q;
  logic             alu_valid_q;
  logic [TAG_W-1:0] alu_tag_q;
  logic [TAG_W-1:0] cnt_q;
  logic [TAG_W-1:0] cnt_d;
  logic             illegal_q;
  logic [ALU_LAT-1:0] res_v_q;
  logic [TAG_W-1:0] res_tag_q [ALU_LAT];

  always_comb begin
    dec_sub   = in_funct7b5 & ~in_is_imm & (in_funct3 == F3_ADD);
    dec_shift = (in_funct3 == F3_SLL) || (in_funct3 == F3_SR);
    dec_legal = 1'b1;
    // Arithmetic right shift is rejected; bit 30 on other R-types is reserved.
    if (in_funct7b5 && (in_funct3 == F3_SR)) dec_legal = 1'b0;
    if (!in_is_imm && in_funct7b5 && (in_funct3 != F3_ADD) && (in_funct3 != F3_SR))
      dec_legal = 1'b0;
    dec_entry.a    = in_rs1;
    dec_entry.ctrl = f3_to_ctrl(in_funct3, dec_sub);
    if (!in_is_imm)     dec_entry.b = in_rs2;
    else if (dec_shift) dec_entry.b = {27'b0, in_imm[4:0]};
    else                dec_entry.b = in_imm;
  end

  assign in_ready = ~fifo_full;
  assign accept   = in_valid & in_ready;
  assign push     = accept & dec_legal;
  assign pop      = (fifo_count != '0) & ~stall;
  assign head     = issue_t'(head_raw);
  assign cnt_d    = cnt_q + TAG_W'(1);

  alu_issue_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ISSUE_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (dec_entry),
    .rdata_o (head_raw),
    .full_o  (fifo_full),
    .count_o (fifo_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_ctrl_q  <= '0;
      alu_valid_q <= 1'b0;
      alu_tag_q   <= '0;
      cnt_q       <= '0;
      illegal_q   <= 1'b0;
    end else begin
      illegal_q   <= accept & ~dec_legal;
      alu_valid_q <= pop;
      if (pop) begin
        alu_a_q    <= head.a;
        alu_b_q    <= head.b;
        alu_ctrl_q <= head.ctrl;
        alu_tag_q  <= cnt_q;
        cnt_q      <= cnt_d;
      end
    end
  end

  // Result-tag pipe tracks the ALU latency and is never held by stall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res_v_q <= '0;
      for (int i = 0; i < ALU_LAT; i++) res_tag_q[i] <= '0;
    end else begin
      res_v_q[0]   <= alu_valid_q;
      res_tag_q[0] <= alu_tag_q;
      for (int i = 1; i < ALU_LAT; i++) begin
        res_v_q[i]   <= res_v_q[i-1];
        res_tag_q[i] <= res_tag_q[i-1];
      end
    end
  end

  assign alu_A     = alu_a_q;
  assign alu_B     = alu_b_q;
  assign alu_ctrl  = alu_ctrl_q;
  assign alu_valid = alu_valid_q;
  assign alu_tag   = alu_tag_q;
  assign res_valid = res_v_q[ALU_LAT-1];
  assign res_tag   = res_tag_q[ALU_LAT-1];
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_issue_queue.sv
// Scoreboard bench for alu_issue_queue: stimulus pushes expected issues,
// a negedge monitor pops and compares whenever the DUT presents an output.
module tb_alu_issue_queue;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_funct3;
  logic        in_funct7b5;
  logic        in_is_imm;
  logic [31:0] in_rs1;
  logic [31:0] in_rs2;
  logic [31:0] in_imm;
  logic        stall;
  logic [31:0] alu_A;
  logic [31:0] alu_B;
  logic [3:0]  alu_ctrl;
  logic        alu_valid;
  logic [2:0]  alu_tag;
  logic        res_valid;
  logic [2:0]  res_tag;
  logic        illegal;

  alu_issue_queue #(.DEPTH(4), .ALU_LAT(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_funct3(in_funct3), .in_funct7b5(in_funct7b5), .in_is_imm(in_is_imm),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .stall(stall),
    .alu_A(alu_A), .alu_B(alu_B), .alu_ctrl(alu_ctrl), .alu_valid(alu_valid),
    .alu_tag(alu_tag), .res_valid(res_valid), .res_tag(res_tag), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ctrl;
    logic [2:0]  tag;
  } exp_t;

  typedef struct {
    logic [2:0]  f3;
    logic        f7;
    logic        imm;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] immv;
    logic [3:0]  ectrl;
    logic [31:0] eb;
  } vec_t;

  int         checks = 0;
  int         errors = 0;
  exp_t       exp_q[$];
  logic [2:0] res_q[$];
  int         exp_ill = 0;
  logic [2:0] exp_tag = '0;
  logic       prev_v = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t       e;
    logic [2:0] t;
    if (reset) begin
      prev_v = 1'b0;
    end else begin
      chk("res_valid_timing", 32'(res_valid), 32'(prev_v));
      if (res_valid) begin
        if (res_q.size() == 0) begin
          chk("res_unexpected", 32'(res_valid), 32'd0);
        end else begin
          t = res_q.pop_front();
          chk("res_tag", 32'(res_tag), 32'(t));
        end
      end
      if (alu_valid) begin
        if (exp_q.size() == 0) begin
          chk("issue_unexpected", 32'(alu_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("alu_A", alu_A, e.a);
          chk("alu_B", alu_B, e.b);
          chk("alu_ctrl", 32'(alu_ctrl), 32'(e.ctrl));
          chk("alu_tag", 32'(alu_tag), 32'(e.tag));
        end
      end
      if (illegal) begin
        chk("illegal_pulse", 32'(exp_ill > 0), 32'd1);
        if (exp_ill > 0) exp_ill--;
      end
      prev_v = alu_valid;
    end
  end

  task automatic send(input logic [2:0] f3, input logic f7, input logic imm_flag,
                      input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm,
                      input logic legal, input logic [3:0] ectrl, input logic [31:0] eb);
    int n = 0;
    in_valid    = 1'b1;
    in_funct3   = f3;
    in_funct7b5 = f7;
    in_is_imm   = imm_flag;
    in_rs1      = rs1;
    in_rs2      = rs2;
    in_imm      = imm;
    while (1) begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 50) begin
        chk("accept_timeout", 32'(in_ready), 32'd1);
        break;
      end
    end
    @(posedge clk);
    if (legal) begin
      exp_q.push_back('{a: rs1, b: eb, ctrl: ectrl, tag: exp_tag});
      res_q.push_back(exp_tag);
      exp_tag++;
    end else begin
      exp_ill++;
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || res_q.size() != 0) && n < 50) begin
      @(posedge clk);
      n++;
    end
    chk("drain_pending", 32'(exp_q.size() + res_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals();
    chk("rst_alu_A", alu_A, 32'd0);
    chk("rst_alu_B", alu_B, 32'd0);
    chk("rst_alu_ctrl", 32'(alu_ctrl), 32'd0);
    chk("rst_alu_valid", 32'(alu_valid), 32'd0);
    chk("rst_alu_tag", 32'(alu_tag), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_tag", 32'(res_tag), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
  endtask

  vec_t stream [10];

  initial begin
    stream[0] = '{3'b010, 1'b0, 1'b0, 32'hFFFFFFFB, 32'd10, 32'd0, ALU_SLT, 32'd10};
    stream[1] = '{3'b011, 1'b0, 1'b0, 32'hFFFFFFFB, 32'd10, 32'd0, ALU_SLTU, 32'd10};
    stream[2] = '{3'b110, 1'b0, 1'b0, 32'd102, 32'd2, 32'd0, ALU_OR, 32'd2};
    stream[3] = '{3'b111, 1'b0, 1'b0, 32'd103, 32'h0F0F0F0F, 32'd0, ALU_AND, 32'h0F0F0F0F};
    stream[4] = '{3'b100, 1'b0, 1'b0, 32'd104, 32'hAAAA5555, 32'd0, ALU_XOR, 32'hAAAA5555};
    stream[5] = '{3'b001, 1'b0, 1'b0, 32'd105, 32'h123, 32'd0, ALU_SLL, 32'h123};
    stream[6] = '{3'b001, 1'b0, 1'b1, 32'd106, 32'h55, 32'hFFFFFFFF, ALU_SLL, 32'h1F};
    stream[7] = '{3'b101, 1'b0, 1'b0, 32'd107, 32'hFFFFFF00, 32'd0, ALU_SRL, 32'hFFFFFF00};
    stream[8] = '{3'b000, 1'b0, 1'b0, 32'd108, 32'd8, 32'd0, ALU_ADD, 32'd8};
    stream[9] = '{3'b110, 1'b0, 1'b1, 32'd109, 32'd9, 32'hFFFFF800, ALU_OR, 32'hFFFFF800};

    reset = 1'b1; in_valid = 1'b0; stall = 1'b0;
    in_funct3 = '0; in_funct7b5 = 1'b0; in_is_imm = 1'b0;
    in_rs1 = '0; in_rs2 = '0; in_imm = '0;
    repeat (2) @(posedge clk);
    #1 check_reset_vals();
    @(negedge clk);
    #2 reset = 1'b0;
    @(posedge clk);
    #1;

    // R-type SUB
    send(3'b000, 1'b1, 1'b0, 32'd10, 32'd5, 32'd0, 1'b1, ALU_SUB, 32'd5);
    drain();

    // shift immediate, illegal forms, I-type ADD with bit 30 set
    send(3'b101, 1'b0, 1'b1, 32'h80, 32'hDEAD, 32'hFFFFFFE2, 1'b1, ALU_SRL, 32'h2);
    send(3'b101, 1'b1, 1'b1, 32'h81, 32'hDEAD, 32'h00000402, 1'b0, ALU_ADD, 32'h0);
    send(3'b001, 1'b1, 1'b0, 32'h82, 32'h3, 32'd0, 1'b0, ALU_ADD, 32'h0);
    send(3'b000, 1'b1, 1'b1, 32'd7, 32'd0, 32'h400, 1'b1, ALU_ADD, 32'h400);
    drain();
    chk("illegal_count", 32'(exp_ill), 32'd0);

    // fill under stall, then full
    stall = 1'b1;
    for (int i = 0; i < 4; i++)
      send(3'b000, 1'b0, 1'b0, 32'(200 + i), 32'(i), 32'd0, 1'b1, ALU_ADD, 32'(i));
    in_valid = 1'b1; in_rs1 = 32'd999;
    @(negedge clk);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("full_in_ready_hold", 32'(in_ready), 32'd0);
    #1 in_valid = 1'b0; stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("burst_issue", 32'(alu_valid), 32'd1);
    end
    @(negedge clk);
    chk("burst_end", 32'(alu_valid), 32'd0);
    chk("ready_after_drain", 32'(in_ready), 32'd1);
    drain();

    // back-to-back stream, tags wrap
    for (int i = 0; i < 10; i++)
      send(stream[i].f3, stream[i].f7, stream[i].imm, stream[i].rs1, stream[i].rs2,
           stream[i].immv, 1'b1, stream[i].ectrl, stream[i].eb);
    drain();

    // reset mid-issue
    stall = 1'b1;
    for (int i = 0; i < 3; i++)
      send(3'b100, 1'b0, 1'b0, 32'(300 + i), 32'(7 * i), 32'd0, 1'b1, ALU_XOR, 32'(7 * i));
    stall = 1'b0;
    @(negedge clk);
    #1 reset = 1'b1;
    #1 check_reset_vals();
    exp_q.delete();
    res_q.delete();
    exp_tag = '0;
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("no_issue_after_reset", 32'(alu_valid), 32'd0);
    send(3'b000, 1'b0, 1'b0, 32'd42, 32'd1, 32'd0, 1'b1, ALU_ADD, 32'd1);
    drain();
    chk("final_illegal_count", 32'(exp_ill), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
